// File: rtl/segment_addr_gen.sv
// Segment:offset physical address generator: reads the selected segment register
// through the segment file read port and issues seg*16 + offset with a wrap flag.
module segment_addr_gen #(
    parameter int SEG_W  = 16,
    parameter int SHIFT  = 4,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_seg,
    input  logic [SEG_W-1:0]  req_offset,
    output logic              seg_we,
    output logic [1:0]        seg_sel,
    input  logic [SEG_W-1:0]  seg_data,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_wrap
);

    localparam int SUM_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       sel_q;
    logic [SEG_W-1:0] offset_q;
    logic [ADDR_W-1:0] addr_q;
    logic             wrap_q;

    logic [SUM_W-1:0] seg_ext;
    logic [SUM_W-1:0] off_ext;
    logic [SUM_W-1:0] sum;

    logic accept;

    assign accept = req_valid && (state == S_IDLE);

    // One extra bit above ADDR_W keeps the carry that drives addr_wrap.
    always_comb begin
        seg_ext = SUM_W'(seg_data) << SHIFT;
        off_ext = SUM_W'(offset_q);
        sum     = seg_ext + off_ext;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_READ;
            S_READ:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_OUT;
            S_OUT:   if (addr_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            sel_q    <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sel_q    <= req_seg;
                offset_q <= req_offset;
            end
            if (state == S_CALC) begin
                addr_q <= sum[ADDR_W-1:0];
                wrap_q <= sum[ADDR_W];
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign seg_we     = 1'b0;
    assign seg_sel    = sel_q;
    assign addr_valid = (state == S_OUT);
    assign addr       = addr_q;
    assign addr_wrap  = wrap_q;

endmodule

// File: tb/tb_segment_addr_gen.sv
// Directed bench for segment_addr_gen with a registered segment-file model.
module tb_segment_addr_gen;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_seg;
    logic [15:0] req_offset;
    logic        seg_we;
    logic [1:0]  seg_sel;
    logic [15:0] seg_data;
    logic        addr_valid;
    logic        addr_ready;
    logic [19:0] addr;
    logic        addr_wrap;

    logic [15:0] segs [4];
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned acc_n;
    int unsigned acc_cyc [16];
    logic        we_seen;

    segment_addr_gen #(.SEG_W(16), .SHIFT(4), .ADDR_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_seg    (req_seg),
        .req_offset (req_offset),
        .seg_we     (seg_we),
        .seg_sel    (seg_sel),
        .seg_data   (seg_data),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr       (addr),
        .addr_wrap  (addr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment file read port: registered Data_Segment output.
    always @(posedge clk) seg_data <= segs[seg_sel];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (req_valid && req_ready && rst) begin
            if (acc_n < 16) acc_cyc[acc_n] = cyc;
            acc_n = acc_n + 1;
        end
    end

    always @(negedge clk) if (seg_we !== 1'b0) we_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single request with addr_ready high; caller is at posedge+1 with DUT idle.
    task automatic do_req(input string tag, input logic [1:0] sel, input logic [15:0] off,
                          input logic [19:0] ea, input logic ew);
        req_seg = sel; req_offset = off; req_valid = 1'b1; addr_ready = 1'b1;
        check({tag, ".rdy"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_seg = ~sel; req_offset = ~off;
        check({tag, ".sel_rd"}, 32'(seg_sel), 32'(sel));
        check({tag, ".val_rd"}, 32'(addr_valid), 32'd0);
        check({tag, ".nrdy"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, ".sel_calc"}, 32'(seg_sel), 32'(sel));
        check({tag, ".val_calc"}, 32'(addr_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".val"}, 32'(addr_valid), 32'd1);
        check({tag, ".addr"}, 32'(addr), 32'(ea));
        check({tag, ".wrap"}, 32'(addr_wrap), 32'(ew));
        check({tag, ".sel_out"}, 32'(seg_sel), 32'(sel));
        @(posedge clk); #1;
        check({tag, ".val_done"}, 32'(addr_valid), 32'd0);
        check({tag, ".rdy_done"}, 32'(req_ready), 32'd1);
        check({tag, ".addr_keep"}, 32'(addr), 32'(ea));
    endtask

    initial begin
        int unsigned base;
        int unsigned got_n;
        logic [19:0] got [4];

        n_vec = 0; n_err = 0; cyc = 0; acc_n = 0; we_seen = 1'b0;
        rst = 1'b0; req_valid = 1'b0; req_seg = 2'b00; req_offset = '0; addr_ready = 1'b0;
        segs[0] = 16'h1234; segs[1] = 16'h2000; segs[2] = 16'h3000; segs[3] = 16'h4000;

        repeat (2) @(posedge clk);
        #1;
        check("rst.val", 32'(addr_valid), 32'd0);
        check("rst.addr", 32'(addr), 32'd0);
        check("rst.wrap", 32'(addr_wrap), 32'd0);
        check("rst.sel", 32'(seg_sel), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst.rdy", 32'(req_ready), 32'd1);

        do_req("cs",  2'b00, 16'h0010, 20'h12350, 1'b0);
        do_req("ds",  2'b01, 16'h0001, 20'h20001, 1'b0);
        do_req("ss",  2'b10, 16'h0001, 20'h30001, 1'b0);
        do_req("es",  2'b11, 16'h0001, 20'h40001, 1'b0);

        segs[2] = 16'hFFFF;
        do_req("wrap1", 2'b10, 16'h0010, 20'h00000, 1'b1);
        segs[3] = 16'hFFFF;
        do_req("wrap2", 2'b11, 16'hFFFF, 20'h0FFEF, 1'b1);
        segs[2] = 16'h3000; segs[3] = 16'h4000;

        // Backpressure: hold OUT for 5 cycles while a second request waits.
        base = acc_n;
        req_seg = 2'b01; req_offset = 16'h0005; req_valid = 1'b1; addr_ready = 1'b0;
        @(posedge clk); #1;
        req_seg = 2'b00; req_offset = 16'h0010;
        repeat (2) @(posedge clk);
        #1;
        check("bp.val0", 32'(addr_valid), 32'd1);
        check("bp.addr0", 32'(addr), 32'h20005);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold_val", 32'(addr_valid), 32'd1);
            check("bp.hold_addr", 32'(addr), 32'h20005);
            check("bp.hold_rdy", 32'(req_ready), 32'd0);
            check("bp.hold_sel", 32'(seg_sel), 32'd1);
        end
        check("bp.acc_blocked", acc_n - base, 32'd1);
        addr_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release_val", 32'(addr_valid), 32'd0);
        check("bp.release_rdy", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp.acc2", acc_n - base, 32'd2);
        check("bp.sel2", 32'(seg_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp.val2", 32'(addr_valid), 32'd1);
        check("bp.addr2", 32'(addr), 32'h12350);
        @(posedge clk); #1;

        // Back-to-back with addr_ready held high.
        base = acc_n; got_n = 0;
        req_seg = 2'b00; req_offset = 16'h0010; req_valid = 1'b1; addr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (acc_n == base + 1) begin
                req_seg = 2'b11; req_offset = 16'h0001;
            end
            if (acc_n >= base + 2) req_valid = 1'b0;
            if (addr_valid && got_n < 4) begin
                got[got_n] = addr;
                got_n = got_n + 1;
            end
        end
        check("b2b.count", got_n, 32'd2);
        check("b2b.addr0", 32'(got[0]), 32'h12350);
        check("b2b.addr1", 32'(got[1]), 32'h40001);
        check("b2b.spacing", acc_cyc[base + 1] - acc_cyc[base], 32'd4);

        // Reset in OUT: address cleared, no address issued afterwards.
        req_seg = 2'b10; req_offset = 16'h0001; req_valid = 1'b1; addr_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mrst.pre_addr", 32'(addr), 32'h30001);
        #2 rst = 1'b0;
        #1;
        check("mrst.val", 32'(addr_valid), 32'd0);
        check("mrst.addr", 32'(addr), 32'd0);
        check("mrst.sel", 32'(seg_sel), 32'd0);
        check("mrst.wrap", 32'(addr_wrap), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; addr_ready = 1'b1;
        check("mrst.rdy", 32'(req_ready), 32'd1);
        got_n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (addr_valid) got_n = got_n + 1;
        end
        check("mrst.no_issue", got_n, 32'd0);

        check("seg_we", 32'(we_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
